// File: rtl/stage_trace_buffer.sv
// Hardware trace probe that qualifies and timestamps pipeline stage words and queues them in a FWFT FIFO.
// Define STAGE_TRACE_TIMESTAMP_EN to build the timestamp counter and per-entry timestamp storage.
module stage_trace_buffer #(
    parameter int DATA_W = 41,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     cap_en,
    input  logic                     change_only,
    input  logic                     stage_valid,
    input  logic [DATA_W-1:0]        stage_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] last_data;
    logic              last_vld;
    logic              overflow_q;
    logic [7:0]        drop_cnt_q;

    logic candidate;
    logic pop;
    logic push;
    logic drop;

    // NOTE: memory arrays carry no reset; emptiness is tracked by count_q and outputs are gated by it.
    logic [DATA_W-1:0] data_mem [DEPTH];

    // A dropped candidate still updates last_data, so change detection sees every qualified sample.
    assign candidate = cap_en & stage_valid &
                       (~change_only | ~last_vld | (stage_data != last_data));
    assign rd_valid  = (count_q != '0);
    assign pop       = rd_valid & rd_ready;
    assign push      = candidate & ((count_q != FULL) | pop);
    assign drop      = candidate & (count_q == FULL) & ~pop;

    always_ff @(posedge clock) begin
        if (push && !clear) begin
            data_mem[wr_ptr] <= stage_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            last_data  <= '0;
            last_vld   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            last_vld   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (candidate) begin
                last_data <= stage_data;
                last_vld  <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    assign rd_data  = rd_valid ? data_mem[rd_ptr] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

`ifdef STAGE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Free-running; clear leaves it alone so captures after a flush keep absolute time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) begin
            ts_mem[wr_ptr] <= ts;
        end
    end

    assign rd_ts = rd_valid ? ts_mem[rd_ptr] : '0;
`else
    assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_stage_trace_buffer.sv
// Self-checking bench for stage_trace_buffer against a queue-based reference model.
module tb_stage_trace_buffer;

    localparam int DATA_W = 41;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef STAGE_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              clear;
    logic              cap_en;
    logic              change_only;
    logic              stage_valid;
    logic [DATA_W-1:0] stage_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    stage_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock(clock), .reset(reset), .clear(clear), .cap_en(cap_en),
        .change_only(change_only), .stage_valid(stage_valid), .stage_data(stage_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [TS_W-1:0]   t;
    } entry_t;

    entry_t            q[$];
    logic [DATA_W-1:0] m_last;
    bit                m_lv;
    int unsigned       m_ts;
    bit                m_ov;
    int                m_dc;
    int                total = 0;
    int                bad   = 0;

    function automatic void model_reset();
        q.delete();
        m_last = '0;
        m_lv   = 1'b0;
        m_ts   = 0;
        m_ov   = 1'b0;
        m_dc   = 0;
    endfunction

    // Applies the capture/queue rules for one clock edge using the inputs currently driven.
    function automatic void model_edge();
        bit     pop, cand, full;
        entry_t e;
        pop  = (q.size() != 0) && rd_ready;
        cand = cap_en && stage_valid && (!change_only || !m_lv || stage_data != m_last);
        if (clear) begin
            q.delete();
            m_ov = 1'b0;
            m_dc = 0;
            m_lv = 1'b0;
        end else begin
            full = (q.size() == DEPTH);
            if (cand) begin
                m_last = stage_data;
                m_lv   = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (cand) begin
                if (!full || pop) begin
                    e.d = stage_data;
                    e.t = TS_EN ? m_ts[TS_W-1:0] : '0;
                    q.push_back(e);
                end else begin
                    m_ov = 1'b1;
                    if (m_dc < 255) m_dc++;
                end
            end
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    function automatic logic [DATA_W-1:0] exp_data();
        return (q.size() != 0) ? q[0].d : '0;
    endfunction

    function automatic logic [TS_W-1:0] exp_ts();
        return (q.size() != 0) ? q[0].t : '0;
    endfunction

    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; cap_en = 0; change_only = 0; stage_valid = 0; rd_ready = 0; stage_data = '0;
    endtask

    task automatic do_clear();
        clear = 1; step(); clear = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); model_reset();
        step(); step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (rd_ts !== '0) begin bad++; $display("FAIL reset_rd_ts got=%0d exp=0", rd_ts); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        reset = 0;
    endtask

    task automatic test_basic();
        logic [TS_W-1:0] first_ts;
        cap_en = 1; stage_valid = 1; change_only = 0; rd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            stage_data = DATA_W'(i);
            step();
        end
        cap_en = 0;
        total++; if (count !== CW'(5)) begin bad++; $display("FAIL basic_count got=%0d exp=5", count); end
        first_ts = rd_ts;
        rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i)) begin
                bad++; $display("FAIL basic_drain[%0d] valid=%0b data=%h exp_data=%h", i, rd_valid, rd_data, DATA_W'(i));
            end
            total++;
            if (rd_ts !== (TS_EN ? first_ts + TS_W'(i) : TS_W'(0)) || rd_ts !== exp_ts()) begin
                bad++; $display("FAIL basic_ts[%0d] got=%0d exp=%0d", i, rd_ts, exp_ts());
            end
            step();
        end
        rd_ready = 0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b exp=0", rd_valid); end
    endtask

    task automatic test_change_only();
        logic [DATA_W-1:0] a, b;
        logic [DATA_W-1:0] seq [5];
        logic [DATA_W-1:0] expv [3];
        a = {$urandom, $urandom};
        b = a ^ DATA_W'(1 + $urandom_range(0, 1000));
        seq  = '{a, a, b, b, a};
        expv = '{a, b, a};
        do_clear();
        cap_en = 1; stage_valid = 1; change_only = 1; rd_ready = 0;
        foreach (seq[i]) begin
            stage_data = seq[i];
            step();
        end
        cap_en = 0;
        total++; if (count !== CW'(3)) begin bad++; $display("FAIL chg_count got=%0d exp=3", count); end
        rd_ready = 1;
        foreach (expv[i]) begin
            total++;
            if (rd_data !== expv[i]) begin bad++; $display("FAIL chg_data[%0d] got=%h exp=%h", i, rd_data, expv[i]); end
            step();
        end
        rd_ready = 0;
        // Same word as last candidate, but the flush forgets it, so it must be taken.
        do_clear();
        cap_en = 1; stage_data = a;
        step();
        cap_en = 0;
        total++;
        if (count !== CW'(1) || rd_data !== a) begin
            bad++; $display("FAIL chg_after_clear count=%0d data=%h exp_count=1 exp_data=%h", count, rd_data, a);
        end
        change_only = 0;
        do_clear();
    endtask

    task automatic test_overflow();
        cap_en = 1; stage_valid = 1; change_only = 0; rd_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            stage_data = {$urandom, $urandom};
            step();
        end
        total++; if (count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", count, DEPTH); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
        stage_data = {$urandom, $urandom};
        rd_ready = 1;
        step();
        rd_ready = 0;
        total++;
        if (count !== CW'(DEPTH) || drop_cnt !== 8'd3 || rd_data !== exp_data()) begin
            bad++; $display("FAIL full_push_pop count=%0d drop=%0d data=%h exp_data=%h", count, drop_cnt, rd_data, exp_data());
        end
        total++;
        if (q[DEPTH-1].d !== stage_data) begin
            bad++; $display("FAIL full_push_pop_tail model_tail=%h exp=%h", q[DEPTH-1].d, stage_data);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            stage_data = {$urandom, $urandom};
            step();
        end
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt); end
        cap_en = 0;
        do_clear();
        total++;
        if (count !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++; $display("FAIL sat_clear count=%0d ovf=%0b drop=%0d exp=0/0/0", count, overflow, drop_cnt);
        end
        cap_en = 1; stage_data = {$urandom, $urandom};
        step();
        cap_en = 0;
        total++;
        if (rd_data !== exp_data() || rd_ts !== exp_ts()) begin
            bad++; $display("FAIL clear_ts_continue data=%h ts=%0d exp_data=%h exp_ts=%0d", rd_data, rd_ts, exp_data(), exp_ts());
        end
        do_clear();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cap_en      = ($urandom_range(0, 9) != 0);
            stage_valid = ($urandom_range(0, 4) != 0);
            change_only = ($urandom_range(0, 2) == 0);
            stage_data  = DATA_W'($urandom_range(0, 3));
            rd_ready    = ($urandom_range(0, 2) != 0) || (i > 300 && i < 350);
            if (i < 300 && i > 250) rd_ready = 0;
            clear       = ($urandom_range(0, 59) == 0);
            step();
            total++;
            if (rd_valid !== (q.size() != 0) || count !== CW'(q.size()) || rd_data !== exp_data() ||
                rd_ts !== exp_ts() || overflow !== m_ov || drop_cnt !== 8'(m_dc)) begin
                bad++;
                $display("FAIL random[%0d] v=%0b cnt=%0d d=%h ts=%0d ovf=%0b drop=%0d exp v=%0b cnt=%0d d=%h ts=%0d ovf=%0b drop=%0d",
                         i, rd_valid, count, rd_data, rd_ts, overflow, drop_cnt,
                         q.size() != 0, q.size(), exp_data(), exp_ts(), m_ov, m_dc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] d0;
        do_clear();
        cap_en = 1; stage_valid = 1; change_only = 0; rd_ready = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            stage_data = {$urandom, $urandom};
            step();
        end
        #3;
        reset = 1;
        model_reset();
        #1;
        total++;
        if (rd_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
            bad++; $display("FAIL async_reset v=%0b cnt=%0d ovf=%0b exp=0/0/0", rd_valid, count, overflow);
        end
        step();
        reset = 0;
        d0 = {$urandom, $urandom};
        stage_data = d0;
        step();
        cap_en = 0;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== d0 || rd_ts !== TS_W'(0)) begin
            bad++; $display("FAIL post_reset_capture v=%0b d=%h ts=%0d exp v=1 d=%h ts=0", rd_valid, rd_data, rd_ts, d0);
        end
        stage_data = {$urandom, $urandom};
        cap_en = 1;
        step();
        cap_en = 0;
        total++;
        if (count !== CW'(2) || q[1].t !== (TS_EN ? TS_W'(1) : TS_W'(0))) begin
            bad++; $display("FAIL post_reset_second cnt=%0d model_ts=%0d exp cnt=2", count, q[1].t);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_change_only();
        test_overflow();
        test_saturate();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
